// File: rtl/axi_soc_pkg.sv
// Shared types and constants for the AXI read-side blocks of the detection SoC.
// Holds the arbiter FSM state type, the AXI widths and the grant-index width helper.
package axi_soc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_LEN_W  = 8;
    localparam int MAX_REQ    = 8;

    function automatic int gnt_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int GNT_IDX_W_MAX = gnt_idx_w(MAX_REQ);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above i_rr_ptr, with wrap.
// Produces a one-hot grant, an any-request flag and the binary index of the winner.
module rr_arbiter
    import axi_soc_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = gnt_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_any_req,
    output logic [IDX_W-1:0]   o_index
);

    int unsigned      w_cand;
    logic [IDX_W-1:0] w_cand_idx;

    always_comb begin
        o_grant    = '0;
        o_any_req  = 1'b0;
        o_index    = '0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            w_cand     = (32'(i_rr_ptr) + off) % NUM_REQ;
            w_cand_idx = IDX_W'(w_cand);
            if (!o_any_req && i_req[w_cand_idx]) begin
                o_any_req           = 1'b1;
                o_grant[w_cand_idx] = 1'b1;
                o_index             = w_cand_idx;
            end
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read master (AR/R) between NUM_REQ requesters, one burst at a time.
// Round-robin grant in IDLE, AR handshake in ADDR, R beats routed to the owner in DATA until RLAST.
module axi_read_arbiter
    import axi_soc_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  ADDR_W  = AXI_ADDR_W,
    parameter int  DATA_W  = 32,
    localparam int IDX_W   = gnt_idx_w(NUM_REQ)
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*AXI_LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_last,
    output logic [ADDR_W-1:0]          ARADDR,
    output logic [AXI_LEN_W-1:0]       ARLEN,
    output logic                       ARVALID,
    input  logic                       ARREADY,
    input  logic [DATA_W-1:0]          RDATA,
    input  logic                       RVALID,
    output logic                       RREADY,
    input  logic                       RLAST,
    output logic                       busy,
    output logic [IDX_W-1:0]           grant_id,
    output logic                       len_err
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [ADDR_W-1:0]      r_araddr;
    logic [AXI_LEN_W-1:0]   r_arlen;
    logic                   r_arvalid;
    logic [IDX_W-1:0]       r_grant_id;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [AXI_LEN_W-1:0]   r_beat_cnt;
    logic                   r_len_err;

    logic [NUM_REQ-1:0]     w_win_onehot;
    logic                   w_any_req;
    logic [IDX_W-1:0]       w_win_idx;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [AXI_LEN_W-1:0]   w_sel_len;
    logic                   w_accept;
    logic                   w_ar_hs;
    logic                   w_beat;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_req     (req_valid),
        .i_rr_ptr  (r_rr_ptr),
        .o_grant   (w_win_onehot),
        .o_any_req (w_any_req),
        .o_index   (w_win_idx)
    );

    always_comb begin
        w_sel_addr = '0;
        w_sel_len  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_win_idx == IDX_W'(i)) begin
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_len  = req_len[i*AXI_LEN_W +: AXI_LEN_W];
            end
        end
    end

    assign w_accept = (r_state == IDLE) && w_any_req;
    assign w_ar_hs  = r_arvalid && ARREADY;
    assign w_beat   = RREADY && RVALID;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (w_any_req)       w_next_state = ADDR;
            ADDR:    if (w_ar_hs)         w_next_state = DATA;
            DATA:    if (w_beat && RLAST) w_next_state = IDLE;
            default:                      w_next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        RREADY    = 1'b0;
        if (r_state == IDLE) begin
            req_ready = w_win_onehot;
        end
        if (r_state == DATA) begin
            RREADY              = rsp_ready[r_grant_id];
            rsp_valid[r_grant_id] = RVALID;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_arvalid  <= 1'b0;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_len_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_araddr   <= w_sel_addr;
                r_arlen    <= w_sel_len;
                r_arvalid  <= 1'b1;
                r_grant_id <= w_win_idx;
                r_beat_cnt <= '0;
            end else if (w_ar_hs) begin
                r_arvalid <= 1'b0;
            end
            if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
                // Covers both early RLAST and missing RLAST on the expected final beat.
                if (RLAST != (r_beat_cnt == r_arlen)) begin
                    r_len_err <= 1'b1;
                end
                if (RLAST) begin
                    r_rr_ptr <= (r_grant_id == IDX_W'(NUM_REQ-1)) ? '0 : r_grant_id + 1'b1;
                end
            end
        end
    end

    assign ARADDR   = r_araddr;
    assign ARLEN    = r_arlen;
    assign ARVALID  = r_arvalid;
    assign rsp_data = RDATA;
    assign rsp_last = RLAST;
    assign busy     = (r_state != IDLE);
    assign grant_id = r_grant_id;
    assign len_err  = r_len_err;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: transaction-level model checked every cycle, directed
// scenarios with literal expectations, then a randomized traffic phase.
module tb_axi_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            ACLK;
    logic            ARESET;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*8-1:0]  req_len;
    logic [DW-1:0]   rsp_data, RDATA;
    logic            rsp_last, ARVALID, ARREADY, RVALID, RREADY, RLAST, busy, len_err;
    logic [AW-1:0]   ARADDR;
    logic [7:0]      ARLEN;
    logic [1:0]      grant_id;

    axi_read_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .ARADDR    (ARADDR),
        .ARLEN     (ARLEN),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .RDATA     (RDATA),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .RLAST     (RLAST),
        .busy      (busy),
        .grant_id  (grant_id),
        .len_err   (len_err)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit            m_init = 0;
    bit            m_active, m_ar_pend, m_lerr;
    int            m_owner, m_prio, m_last_grant, m_beats;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_len;

    task automatic model_cycle();
        int         win;
        logic [N-1:0] e_ready, e_rv;
        bit         in_data;
        win = -1;
        if (!m_active) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_prio + k) % N;
                if (win < 0 && req_valid[c] === 1'b1) win = c;
            end
        end
        in_data = m_active && !m_ar_pend;
        if (m_init) begin
            e_ready = '0;
            if (win >= 0) e_ready[win] = 1'b1;
            e_rv = '0;
            if (in_data && RVALID) e_rv[m_owner] = 1'b1;
            chk("busy", busy, m_active);
            chk("req_ready", req_ready, e_ready);
            chk("grant_id", grant_id, m_last_grant);
            chk("len_err", len_err, m_lerr);
            chk("ARVALID", ARVALID, m_active && m_ar_pend);
            if (m_active && m_ar_pend) begin
                chk("ARADDR", ARADDR, m_addr);
                chk("ARLEN", ARLEN, m_len);
            end
            chk("RREADY", RREADY, in_data ? rsp_ready[m_owner] : 1'b0);
            chk("rsp_valid", rsp_valid, e_rv);
            if (e_rv != '0) begin
                chk("rsp_data", rsp_data, RDATA);
                chk("rsp_last", rsp_last, RLAST);
            end
        end
        if (ARESET) begin
            m_init = 1; m_active = 0; m_ar_pend = 0; m_lerr = 0;
            m_prio = 0; m_last_grant = 0; m_beats = 0; m_owner = 0;
        end else if (m_init) begin
            if (!m_active) begin
                if (win >= 0) begin
                    m_active = 1; m_ar_pend = 1; m_owner = win; m_last_grant = win;
                    m_addr = req_addr[win*AW +: AW];
                    m_len  = req_len[win*8 +: 8];
                    m_beats = 0;
                end
            end else if (m_ar_pend) begin
                if (ARREADY) m_ar_pend = 0;
            end else if (RVALID && rsp_ready[m_owner]) begin
                if (RLAST && (m_beats % 256) != int'(m_len)) m_lerr = 1;
                if (!RLAST && (m_beats % 256) == int'(m_len)) m_lerr = 1;
                m_beats++;
                if (RLAST) begin
                    m_active = 0;
                    m_prio = (m_owner + 1) % N;
                end
            end
        end
    endtask

    initial begin : compare
        forever begin
            @(negedge ACLK);
            model_cycle();
        end
    end

    // ---------------- requesters, slave and event logs ----------------
    bit            want[N];
    int            rep[N];
    logic [AW-1:0] q_addr[N];
    logic [7:0]    q_len[N];
    int            cfg_ar_delay = 0, cfg_force = 0, cfg_rr_mode = 0, rand_left = 0;
    bit            cfg_ar_always = 0, cfg_rv_rand = 0, cfg_rand_data = 0, cfg_rand = 0;
    logic [DW-1:0] cfg_base = '0;
    bit            sl_active = 0, tog = 0, pend_last = 0;
    int            sl_total = 0, sl_beat = 0, ar_wait = 0, cyc = 0;

    int            grant_q[$];
    int            gcyc_q[$];
    logic [39:0]   ar_q[$];
    logic [DW-1:0] data_q[$];
    logic          busy_after_last[$];
    int            beats_to[N];
    int            last_seen = 0, last_idx = 0, arv_cycles = 0;

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = want[i];
            req_addr[i*AW +: AW]  = q_addr[i];
            req_len[i*8 +: 8]     = q_len[i];
        end
    endtask

    task automatic post(input int i, input logic [AW-1:0] a, input logic [7:0] l, input int r);
        want[i] = 1; q_addr[i] = a; q_len[i] = l; rep[i] = r;
        drive_reqs();
    endtask

    task automatic clear_logs();
        grant_q.delete(); gcyc_q.delete(); ar_q.delete(); data_q.delete();
        busy_after_last.delete();
        for (int i = 0; i < N; i++) beats_to[i] = 0;
        last_seen = 0; last_idx = 0; arv_cycles = 0;
    endtask

    task automatic step();
        logic [N-1:0] acc;
        bit           ar_hs, r_hs, r_last, rst_now, rv_s;
        logic [7:0]   ar_len_s;
        @(negedge ACLK);
        rst_now  = (ARESET === 1'b1);
        acc      = req_ready & req_valid;
        ar_hs    = (ARVALID === 1'b1) && (ARREADY === 1'b1);
        rv_s     = (RVALID === 1'b1);
        r_hs     = rv_s && (RREADY === 1'b1);
        r_last   = r_hs && (RLAST === 1'b1);
        ar_len_s = ARLEN;
        if (pend_last) begin busy_after_last.push_back(busy); pend_last = 0; end
        if (!rst_now) begin
            if (ARVALID === 1'b1) arv_cycles++;
            for (int i = 0; i < N; i++) begin
                if (acc[i] === 1'b1) begin grant_q.push_back(i); gcyc_q.push_back(cyc); end
                if (r_hs && rsp_valid[i] === 1'b1) begin
                    beats_to[i]++;
                    data_q.push_back(rsp_data);
                    if (rsp_last === 1'b1) begin last_seen++; last_idx = beats_to[i]; end
                end
            end
            if (ar_hs) ar_q.push_back({ARLEN, ARADDR});
        end
        @(posedge ACLK);
        cyc++;
        #1;
        if (rst_now) begin
            sl_active = 0; RVALID = 0; RLAST = 0; ARREADY = 0; ar_wait = 0;
            for (int i = 0; i < N; i++) want[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (acc[i] === 1'b1) begin
                    if (rep[i] > 0) rep[i]--;
                    else want[i] = 0;
                end
            end
            if (r_last) pend_last = 1;
            if (ar_hs) begin
                sl_active = 1; sl_beat = 0;
                sl_total  = (cfg_force > 0) ? cfg_force : int'(ar_len_s) + 1;
                if (cfg_rand) cfg_ar_delay = $urandom_range(0, 3);
            end
            if (r_hs) begin
                sl_beat++;
                if (r_last) sl_active = 0;
            end
            if (cfg_ar_always) ARREADY = 1;
            else if (ARVALID === 1'b1 && !sl_active) begin
                ARREADY = (ar_wait >= cfg_ar_delay);
                ar_wait++;
            end else begin
                ARREADY = 0; ar_wait = 0;
            end
            if (!sl_active) begin
                RVALID = 0; RLAST = 0;
            end else if (!(rv_s && !r_hs)) begin
                RVALID = cfg_rv_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
                RDATA  = cfg_rand_data ? $urandom : cfg_base + DW'(sl_beat);
                RLAST  = (sl_beat == sl_total - 1);
            end
            if (cfg_rand) begin
                for (int i = 0; i < N; i++) begin
                    if (!want[i] && rand_left > 0 && $urandom_range(0, 5) == 0) begin
                        want[i] = 1; rep[i] = 0;
                        q_addr[i] = $urandom & ~32'h3;
                        q_len[i]  = 8'($urandom_range(0, 7));
                        rand_left--;
                    end
                end
            end
        end
        case (cfg_rr_mode)
            1:       rsp_ready = N'($urandom);
            2:       begin tog = !tog; rsp_ready = tog ? '1 : '0; end
            default: rsp_ready = '1;
        endcase
        drive_reqs();
    endtask

    function automatic bit all_idle();
        bit any_want;
        any_want = 0;
        for (int i = 0; i < N; i++) if (want[i]) any_want = 1;
        return !any_want && !sl_active && busy === 1'b0 && ARVALID !== 1'b1 && rand_left == 0;
    endfunction

    task automatic wait_idle(input int budget, input string name);
        bit done;
        done = 0;
        for (int t = 0; t < budget && !done; t++) begin
            step();
            if (all_idle()) done = 1;
        end
        step();
        chk({name, "_completed"}, done, 1'b1);
    endtask

    task automatic do_reset();
        ARESET = 1;
        step();
        ARESET = 0;
    endtask

    initial begin : main
        int exp_ord[8];
        bit reached;
        ARESET = 1; ARREADY = 0; RVALID = 0; RLAST = 0; RDATA = '0;
        rsp_ready = '1; req_valid = '0; req_addr = '0; req_len = '0;
        for (int i = 0; i < N; i++) begin want[i] = 0; rep[i] = 0; q_addr[i] = '0; q_len[i] = '0; end
        step(); step();
        ARESET = 0;
        #1;
        chk("rst_ARADDR", ARADDR, 0);
        chk("rst_ARLEN", ARLEN, 0);
        chk("rst_ARVALID", ARVALID, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_len_err", len_err, 0);

        // single requester, ARREADY after 2 cycles, 16 beats
        clear_logs(); cfg_ar_delay = 2; cfg_base = '0;
        post(0, 32'h1000, 8'd15, 0);
        wait_idle(200, "s1");
        chk("s1_ar_count", ar_q.size(), 1);
        if (ar_q.size() == 1) begin
            chk("s1_araddr", ar_q[0][31:0], 32'h1000);
            chk("s1_arlen", ar_q[0][39:32], 15);
        end
        chk("s1_beats", beats_to[0], 16);
        if (data_q.size() == 16)
            for (int k = 0; k < 16; k++) chk("s1_data", data_q[k], k);
        chk("s1_last_count", last_seen, 1);
        chk("s1_last_on_beat", last_idx, 16);
        chk("s1_len_err", len_err, 0);
        chk("s1_busy_samples", busy_after_last.size(), 1);
        if (busy_after_last.size() == 1) chk("s1_busy_after_last", busy_after_last[0], 0);

        // round-robin order
        do_reset();
        clear_logs();
        for (int i = 0; i < N; i++) post(i, 32'h100 * (i + 1), 8'd3, 0);
        wait_idle(400, "s2a");
        post(0, 32'h8000, 8'd3, 1);
        post(2, 32'h9000, 8'd3, 1);
        wait_idle(400, "s2b");
        exp_ord = '{0, 1, 2, 3, 0, 2, 0, 2};
        chk("s2_grant_count", grant_q.size(), 8);
        if (grant_q.size() == 8)
            for (int k = 0; k < 8; k++) chk("s2_grant_order", grant_q[k], exp_ord[k]);

        // backpressure on requester 1
        clear_logs(); cfg_rr_mode = 2; tog = 0; cfg_base = 32'hA0;
        post(1, 32'h2000, 8'd7, 0);
        wait_idle(400, "s3");
        cfg_rr_mode = 0;
        chk("s3_beats", beats_to[1], 8);
        if (data_q.size() == 8)
            for (int k = 0; k < 8; k++) chk("s3_data_order", data_q[k], 32'hA0 + k);
        chk("s3_last_count", last_seen, 1);

        // length mismatch: early RLAST, then late RLAST
        clear_logs(); cfg_force = 2;
        post(2, 32'h3000, 8'd3, 0);
        wait_idle(200, "s4a");
        chk("s4_len_err_set", len_err, 1);
        clear_logs(); cfg_force = 3;
        post(2, 32'h3100, 8'd1, 0);
        reached = 0;
        for (int t = 0; t < 200 && !reached; t++) begin
            step();
            if (beats_to[2] >= 2) reached = 1;
        end
        chk("s4_two_beats_reached", reached, 1);
        #1;
        chk("s4_still_busy", busy, 1);
        wait_idle(200, "s4b");
        chk("s4_total_beats", beats_to[2], 3);
        chk("s4_len_err_sticky", len_err, 1);
        cfg_force = 0;

        // reset mid-burst on beat 5 of 16
        clear_logs();
        post(0, 32'h4000, 8'd15, 0);
        reached = 0;
        for (int t = 0; t < 200 && !reached; t++) begin
            step();
            if (beats_to[0] >= 4) reached = 1;
        end
        chk("s5_beat4_reached", reached, 1);
        do_reset();
        #1;
        chk("s5_busy", busy, 0);
        chk("s5_ARVALID", ARVALID, 0);
        chk("s5_RREADY", RREADY, 0);
        chk("s5_rsp_valid", rsp_valid, 0);
        chk("s5_grant_id", grant_id, 0);
        chk("s5_len_err", len_err, 0);
        clear_logs();
        post(1, 32'h5000, 8'd2, 0);
        wait_idle(200, "s5b");
        chk("s5_new_beats", beats_to[1], 3);
        if (ar_q.size() == 1) chk("s5_new_araddr", ar_q[0][31:0], 32'h5000);

        // single-beat bursts with ARREADY held high
        clear_logs(); cfg_ar_always = 1;
        post(3, 32'h6000, 8'd0, 1);
        wait_idle(200, "s6");
        chk("s6_grants", grant_q.size(), 2);
        if (gcyc_q.size() == 2) chk("s6_regrant_gap", gcyc_q[1] - gcyc_q[0], 3);
        chk("s6_arvalid_cycles", arv_cycles, 2);
        chk("s6_beats", beats_to[3], 2);
        chk("s6_lasts", last_seen, 2);
        cfg_ar_always = 0;

        // randomized traffic
        clear_logs();
        cfg_rand = 1; cfg_rr_mode = 1; cfg_rv_rand = 1; cfg_rand_data = 1; rand_left = 40;
        wait_idle(20000, "rand");
        chk("rand_grants", grant_q.size(), 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Round-robin scheduler that shares one AXI4 read master port (AR and R channels) between NUM_REQ internal requesters, e.g. feature-map and weight fetch engines in the detection SoC.
- Accepts one burst request (address, length) at a time, drives AR, routes R beats back to the granted requester until RLAST, then re-arbitrates.
- Only one burst is outstanding at any time; there is no ID-based interleaving.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 32, read data width

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester burst request valid
req_ready  out  NUM_REQ  per-requester request accept (one-hot or zero)
req_addr  in  NUM_REQ*ADDR_W  packed start addresses; requester i at [i*ADDR_W +: ADDR_W]
req_len  in  NUM_REQ*8  packed AXI lengths (beats-1)
rsp_valid  out  NUM_REQ  per-requester read beat valid (one-hot or zero)
rsp_ready  in  NUM_REQ  per-requester beat accept
rsp_data  out  DATA_W  read data, shared by all requesters
rsp_last  out  1  last beat of burst, qualified by rsp_valid
ARADDR  out  ADDR_W  AXI read address
ARLEN  out  8  AXI burst length
ARVALID  out  1  AXI address valid
ARREADY  in  1  AXI address ready
RDATA  in  DATA_W  AXI read data
RVALID  in  1  AXI read valid
RREADY  out  1  AXI read ready
RLAST  in  1  AXI last beat
busy  out  1  state != IDLE
grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester
len_err  out  1  sticky beat-count mismatch flag

Behaviour:
- Reset (ARESET=1 at a rising edge of ACLK):
  - state=IDLE; ARADDR=0, ARLEN=0, ARVALID=0; grant_id=0; rr_ptr=0; beat_cnt=0; len_err=0.
  - Reset mid-burst abandons the burst. No R-beat handling is required after reset.
- FSM states are IDLE, ADDR, DATA.
- IDLE:
  - The winner is the first asserted req_valid searching from rr_ptr upward, with wrap.
  - req_ready[winner]=1 combinationally, only in IDLE. All other req_ready bits are 0.
  - On accept, the cycle ends with: ARADDR/ARLEN loaded from the winner, ARVALID=1, grant_id=winner, beat_cnt=0, state→ADDR.
  - With no valid requests, the FSM stays in IDLE.
- ADDR:
  - ARVALID is held with ARADDR/ARLEN stable until ARREADY.
  - On ARVALID&&ARREADY: ARVALID→0, state→DATA.
- DATA:
  - RREADY = rsp_ready[grant_id].
  - rsp_valid[grant_id] = RVALID; all other rsp_valid bits are 0.
  - rsp_data = RDATA and rsp_last = RLAST, passed through combinationally.
  - On each beat (RVALID&&RREADY): beat_cnt increments, 8-bit, wrapping.
  - On a beat with RLAST: state→IDLE, rr_ptr→grant_id+1 (mod NUM_REQ).
- Outside DATA: RREADY=0 and rsp_valid=0.
- Latency:
  - Request accept at cycle N gives ARVALID at cycle N+1.
  - R channel to requester is zero latency (combinational).
  - Earliest re-grant is the cycle after the RLAST beat.
- len_err is set (sticky until reset) when either:
  - RLAST arrives on a beat where beat_cnt != ARLEN, or
  - a beat arrives with beat_cnt == ARLEN and no RLAST.
- The FSM always ends the burst on RLAST only. A missing RLAST keeps it in DATA indefinitely.
- Requesters must hold req_valid/addr/len stable until req_ready. The arbiter does not latch unaccepted requests.
- Simultaneous requests: strict round-robin. The requester just served has lowest priority next time.
- ARLEN=0 (single beat) is legal: one DATA beat with RLAST.

Decomposition:
- Package axi_soc_pkg:
  - state enum (IDLE, ADDR, DATA)
  - AXI width constants (AXI_ADDR_W=32, AXI_LEN_W=8)
  - localparam for the grant index width
- Sub-module rr_arbiter (NUM_REQ): combinational round-robin pick.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, any_req, index.
- The arbiter is instantiated once inside axi_read_arbiter; the FSM and counters stay in the top module.

Test Plan:
- Single requester:
  - Stimulus: req 0 with addr 0x1000, len 15; slave ARREADY after 2 cycles; 16 beats 0x0..0xF.
  - Required: ARADDR=0x1000, ARLEN=15; requester 0 sees 16 beats with rsp_last on beat 16; len_err=0; busy drops the cycle after RLAST.
- Round-robin:
  - Stimulus: req 0..3 all valid, len 3 each, held until accepted.
  - Required: grant order 0,1,2,3.
  - Stimulus: then req 0 and 2 held valid.
  - Required: order 0,2,0,2; no requester starved.
- Backpressure:
  - Stimulus: rsp_ready[1] toggles 1010 during a len-7 burst to requester 1.
  - Required: RREADY mirrors rsp_ready; exactly 8 beats delivered; data order preserved.
- Length mismatch:
  - Stimulus: ARLEN=3 but the slave asserts RLAST on beat 2; then a separate ARLEN=1 burst with no RLAST on beat 2.
  - Required: len_err=1 after the first case and stays set.
  - Required for the second case: FSM stays in DATA until RLAST.
- Reset mid-burst:
  - Stimulus: ARESET=1 for 1 cycle during DATA beat 5 of 16.
  - Required next cycle: busy=0, ARVALID=0, RREADY=0, rsp_valid=0, grant_id=0, len_err=0.
  - Required: a new request is accepted normally.
- Single-beat burst with ARREADY already high:
  - Stimulus: req 3 with len 0.
  - Required: ARVALID for exactly 1 cycle; 1 beat with rsp_last; re-grant possible 3 cycles after the original accept.
